// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide unit with HI/LO registers
module mult_div_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [63:0]   acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0]   mcand;    // multiplicand or divisor magnitude
    logic          is_div;
    logic          neg_res;  // product / quotient must be negated
    logic          neg_rem;  // remainder takes the dividend's sign
    logic          div0;

    logic          md_start;
    logic          sgn;
    logic [31:0]   abs_a, abs_b;
    logic [32:0]   mul_sum;
    logic [63:0]   mul_next;
    logic [32:0]   div_shift;
    logic [32:0]   div_diff;
    logic [63:0]   div_next;
    logic [63:0]   prod_fix;
    logic [31:0]   quot_fix, rem_fix;

    assign md_start = start && !op[2];
    assign sgn      = !op[0];
    assign abs_a    = (sgn && a[31]) ? -a : a;
    assign abs_b    = (sgn && b[31]) ? -b : b;

    // One radix-2 step for each datapath, plus final sign correction
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
        mul_next  = {mul_sum, acc[31:1]};
        div_shift = acc[63:31];
        div_diff  = div_shift - {1'b0, mcand};
        if (div_shift >= {1'b0, mcand})
            div_next = {div_diff[31:0], acc[30:0], 1'b1};
        else
            div_next = {acc[62:0], 1'b0};
        prod_fix  = neg_res ? -acc : acc;
        // a zero divisor keeps the all-ones quotient regardless of operand signs
        quot_fix  = (neg_res && !div0) ? -acc[31:0] : acc[31:0];
        rem_fix   = neg_rem ? -acc[63:32] : acc[63:32];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; cancel overrides every transition
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (md_start && !cancel) state_nx = CALC;
            CALC: if (cancel) state_nx = IDLE;
                  else if (cnt == CW'(ITER - 1)) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs derived from the registered state
    always_comb begin
        busy  = (state != IDLE);
        stall = busy || md_start;
    end

    // Datapath, HI/LO and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        if (md_start) begin
                            cnt     <= '0;
                            is_div  <= op[1];
                            neg_res <= sgn && (a[31] ^ b[31]);
                            neg_rem <= sgn && a[31];
                            div0    <= (b == 32'd0);
                            if (op[1]) begin
                                acc   <= {32'd0, abs_a};
                                mcand <= abs_b;
                            end else begin
                                acc   <= {32'd0, abs_b};
                                mcand <= abs_a;
                            end
                        end else if (op == 3'b100) begin
                            hi <= a;
                        end else if (op == 3'b101) begin
                            lo <= a;
                        end
                    end
                end
                CALC: begin
                    if (!cancel) begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (!cancel) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
